// File: rtl/controlador_vga_if.sv
// Video timing bundle from the VGA timing generator to the pixel/colour generator.
interface controlador_vga_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixelX;
    logic [9:0] pixelY;

    modport master (output hsync, output vsync, output video_on, output pixelX, output pixelY);
    modport slave  (input  hsync, input  vsync, input  video_on, input  pixelX, input  pixelY);
endinterface

// File: rtl/controlador_vga.sv
// Free-running 640x480@60 VGA timing generator: raster counters plus registered
// sync, visible-area flag and pixel coordinates, all one cycle behind the counters.
module controlador_vga #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned SYNC_ACTIVE = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    controlador_vga_if.master     vga_o
);
    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        SYNC_ON  = 1'(SYNC_ACTIVE);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          video_on_q, video_on_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    // Raster advance and output decode from the current counter values.
    always_comb begin
        hcnt_d     = hcnt_q + CW'(1);
        vcnt_d     = vcnt_q;
        pixel_x_d  = hcnt_q;
        pixel_y_d  = vcnt_q;
        video_on_d = (hcnt_q < CW'(H_VISIBLE)) && (vcnt_q < CW'(V_VISIBLE));
        hsync_d    = ~SYNC_ON;
        vsync_d    = ~SYNC_ON;

        if (hcnt_q == CW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == CW'(V_TOTAL - 1)) ? '0 : vcnt_q + CW'(1);
        end

        if ((hcnt_q >= CW'(HS_START)) && (hcnt_q < CW'(HS_END))) begin
            hsync_d = SYNC_ON;
        end
        // vsync depends on the line only, so it spans whole lines.
        if ((vcnt_q >= CW'(VS_START)) && (vcnt_q < CW'(VS_END))) begin
            vsync_d = SYNC_ON;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            pixel_x_q  <= '0;
            pixel_y_q  <= '0;
            video_on_q <= 1'b0;
            hsync_q    <= ~SYNC_ON;
            vsync_q    <= ~SYNC_ON;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            pixel_x_q  <= pixel_x_d;
            pixel_y_q  <= pixel_y_d;
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign vga_o.pixelX   = pixel_x_q;
    assign vga_o.pixelY   = pixel_y_q;
    assign vga_o.video_on = video_on_q;
    assign vga_o.hsync    = hsync_q;
    assign vga_o.vsync    = vsync_q;
endmodule

// File: tb/tb_controlador_vga.sv
// Directed bench: full-size timing instance plus a short-frame, active-high-sync
// instance so whole-frame behaviour fits in a short run.
module tb_controlador_vga;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   pix     = 0;

    always #5 clock = ~clock;

    controlador_vga_if vga_d ();
    controlador_vga_if vga_s ();

    controlador_vga dut_d (
        .clock   (clock),
        .reset_n (reset_n),
        .vga_o   (vga_d)
    );

    // Small frame: 4 visible lines, vsync on lines 6..7, 11 lines total, sync active-high.
    controlador_vga #(
        .V_VISIBLE   (4),
        .V_FRONT     (2),
        .V_SYNC      (2),
        .V_BACK      (3),
        .SYNC_ACTIVE (1)
    ) dut_s (
        .clock   (clock),
        .reset_n (reset_n),
        .vga_o   (vga_s)
    );

    task automatic step();
        @(posedge clock);
        #1;
        pix++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.pixelY !== 10'd0) begin bad++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", vga_d.pixelX, vga_d.pixelY); end
        total++; if (vga_d.video_on !== 1'b0) begin bad++; $display("FAIL rst_video got=%b exp=0", vga_d.video_on); end
        total++; if (vga_d.hsync !== 1'b1 || vga_d.vsync !== 1'b1) begin bad++; $display("FAIL rst_sync got=%b%b exp=11", vga_d.hsync, vga_d.vsync); end
        total++; if (vga_s.hsync !== 1'b0 || vga_s.vsync !== 1'b0) begin bad++; $display("FAIL rst_sync_hi got=%b%b exp=00", vga_s.hsync, vga_s.vsync); end
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.video_on !== 1'b0) begin bad++; $display("FAIL rst_glitch got x=%0d v=%b exp x=0 v=0", vga_d.pixelX, vga_d.video_on); end
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        pix = 0;
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.pixelY !== 10'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d exp=0,0", vga_d.pixelX, vga_d.pixelY); end
        total++; if (vga_d.video_on !== 1'b1) begin bad++; $display("FAIL first_video got=%b exp=1", vga_d.video_on); end
        total++; if (vga_d.hsync !== 1'b1 || vga_d.vsync !== 1'b1) begin bad++; $display("FAIL first_sync got=%b%b exp=11", vga_d.hsync, vga_d.vsync); end
        total++; if (vga_s.video_on !== 1'b1 || vga_s.hsync !== 1'b0) begin bad++; $display("FAIL first_small got v=%b hs=%b exp v=1 hs=0", vga_s.video_on, vga_s.hsync); end
    endtask

    task automatic test_horizontal_sweep();
        int vid_cnt = 0;
        int hs_cnt  = 0;
        int hs_first = -1;
        int hs_last  = -1;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) step();
            total++; if (vga_d.pixelX !== 10'(k) || vga_d.pixelY !== 10'd0) begin bad++; $display("FAIL hsweep_xy got=%0d,%0d exp=%0d,0", vga_d.pixelX, vga_d.pixelY, k); end
            total++; if (vga_d.video_on !== (k < 640)) begin bad++; $display("FAIL hsweep_video x=%0d got=%b exp=%b", k, vga_d.video_on, (k < 640)); end
            total++; if (vga_d.hsync !== !(k >= 656 && k < 752)) begin bad++; $display("FAIL hsweep_hsync x=%0d got=%b exp=%b", k, vga_d.hsync, !(k >= 656 && k < 752)); end
            if (vga_d.video_on === 1'b1) vid_cnt++;
            if (vga_d.hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
                hs_last = k;
            end
        end
        step();
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.pixelY !== 10'd1) begin bad++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", vga_d.pixelX, vga_d.pixelY); end
        total++; if (vid_cnt != 640) begin bad++; $display("FAIL line_video_cnt got=%0d exp=640", vid_cnt); end
        total++; if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
        total++; if (hs_first != 656 || hs_last != 751) begin bad++; $display("FAIL hsync_span got=%0d..%0d exp=656..751", hs_first, hs_last); end
    endtask

    task automatic test_hsync_period();
        logic prev = vga_d.hsync;
        int   falls[2];
        int   n = 0;
        for (int k = 0; k < 2000 && n < 2; k++) begin
            step();
            if (prev === 1'b1 && vga_d.hsync === 1'b0) begin
                falls[n] = pix;
                n++;
                total++; if (vga_d.pixelX !== 10'd656) begin bad++; $display("FAIL hsync_fall_x got=%0d exp=656", vga_d.pixelX); end
            end
            prev = vga_d.hsync;
        end
        total++;
        if (n < 2) begin bad++; $display("FAIL hsync_period got=%0d edges exp=2", n); end
        else if (falls[1] - falls[0] != 800) begin bad++; $display("FAIL hsync_period got=%0d exp=800", falls[1] - falls[0]); end
    endtask

    task automatic test_vertical_sweep();
        int   vs_cnt  = 0;
        int   vid_cnt = 0;
        int   y_max   = 0;
        int   n       = 0;
        int   rises[2];
        logic prev = vga_s.vsync;
        for (int k = 0; k < 17600; k++) begin
            int ex, eys, eyd;
            step();
            ex  = pix % 800;
            eys = (pix / 800) % 11;
            eyd = (pix / 800) % 525;
            total++; if (vga_s.pixelX !== 10'(ex) || vga_s.pixelY !== 10'(eys)) begin bad++; $display("FAIL vsweep_xy got=%0d,%0d exp=%0d,%0d", vga_s.pixelX, vga_s.pixelY, ex, eys); end
            total++; if (vga_s.video_on !== (ex < 640 && eys < 4)) begin bad++; $display("FAIL vsweep_video y=%0d x=%0d got=%b", eys, ex, vga_s.video_on); end
            total++; if (vga_s.vsync !== (eys == 6 || eys == 7)) begin bad++; $display("FAIL vsweep_vsync y=%0d got=%b", eys, vga_s.vsync); end
            total++; if (vga_s.hsync !== (ex >= 656 && ex < 752)) begin bad++; $display("FAIL vsweep_hsync x=%0d got=%b", ex, vga_s.hsync); end
            total++; if (vga_d.pixelY !== 10'(eyd) || vga_d.vsync !== 1'b1 || vga_d.video_on !== (ex < 640)) begin bad++; $display("FAIL full_rows y=%0d got y=%0d vs=%b v=%b", eyd, vga_d.pixelY, vga_d.vsync, vga_d.video_on); end
            if (k < 8800) begin
                if (vga_s.vsync === 1'b1) vs_cnt++;
                if (vga_s.video_on === 1'b1) vid_cnt++;
                if (int'(vga_s.pixelY) > y_max) y_max = int'(vga_s.pixelY);
            end
            if (prev === 1'b0 && vga_s.vsync === 1'b1 && n < 2) begin rises[n] = pix; n++; end
            prev = vga_s.vsync;
        end
        total++; if (vs_cnt != 1600) begin bad++; $display("FAIL vsync_width got=%0d exp=1600", vs_cnt); end
        total++; if (vid_cnt != 2560) begin bad++; $display("FAIL frame_video_cnt got=%0d exp=2560", vid_cnt); end
        total++; if (y_max != 10) begin bad++; $display("FAIL y_max got=%0d exp=10", y_max); end
        total++;
        if (n < 2) begin bad++; $display("FAIL vsync_period got=%0d edges exp=2", n); end
        else if (rises[1] - rises[0] != 8800) begin bad++; $display("FAIL vsync_period got=%0d exp=8800", rises[1] - rises[0]); end
    endtask

    task automatic test_wrap_corner();
        int k = 0;
        while (!(vga_s.pixelX === 10'd799 && vga_s.pixelY === 10'd10) && k < 9000) begin
            step();
            k++;
        end
        total++;
        if (k >= 9000) begin bad++; $display("FAIL wrap_reach got=timeout exp=(799,10)"); end
        else begin
            step();
            total++; if (vga_s.pixelX !== 10'd0 || vga_s.pixelY !== 10'd0) begin bad++; $display("FAIL wrap_xy got=%0d,%0d exp=0,0", vga_s.pixelX, vga_s.pixelY); end
            total++; if (vga_s.video_on !== 1'b1 || vga_s.hsync !== 1'b0 || vga_s.vsync !== 1'b0) begin bad++; $display("FAIL wrap_flags got v=%b hs=%b vs=%b exp v=1 hs=0 vs=0", vga_s.video_on, vga_s.hsync, vga_s.vsync); end
        end
    endtask

    task automatic test_mid_frame_reset();
        int k = 0;
        while (!(vga_s.pixelX === 10'd300 && vga_s.pixelY === 10'd2) && k < 9000) begin
            step();
            k++;
        end
        total++; if (k >= 9000) begin bad++; $display("FAIL midrst_reach got=timeout exp=(300,2)"); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (vga_s.pixelX !== 10'd0 || vga_s.pixelY !== 10'd0 || vga_s.video_on !== 1'b0) begin bad++; $display("FAIL midrst_small got=%0d,%0d v=%b exp=0,0 v=0", vga_s.pixelX, vga_s.pixelY, vga_s.video_on); end
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.pixelY !== 10'd0 || vga_d.hsync !== 1'b1 || vga_d.vsync !== 1'b1) begin bad++; $display("FAIL midrst_full got=%0d,%0d hs=%b vs=%b", vga_d.pixelX, vga_d.pixelY, vga_d.hsync, vga_d.vsync); end
        repeat (2) @(posedge clock);
        #1;
        total++; if (vga_d.pixelX !== 10'd0 || vga_d.video_on !== 1'b0) begin bad++; $display("FAIL midrst_hold got x=%0d v=%b exp x=0 v=0", vga_d.pixelX, vga_d.video_on); end
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        pix = 0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            total++; if (vga_d.pixelX !== 10'(j) || vga_d.pixelY !== 10'd0 || vga_d.video_on !== 1'b1) begin bad++; $display("FAIL restart_full got=%0d,%0d v=%b exp=%0d,0 v=1", vga_d.pixelX, vga_d.pixelY, vga_d.video_on, j); end
            total++; if (vga_s.pixelX !== 10'(j) || vga_s.pixelY !== 10'd0) begin bad++; $display("FAIL restart_small got=%0d,%0d exp=%0d,0", vga_s.pixelX, vga_s.pixelY, j); end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal_sweep();
        test_hsync_period();
        test_vertical_sweep();
        test_wrap_corner();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
